// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // LO after a divide by zero is this bit replicated across the word (all-ones).
    localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the HI/LO sequencer.
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = hilo_muldiv_ctrl_pkg::WIDTH_DEF
) ();

    logic             start;
    logic             op;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cancel;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, is_signed, A, B, cancel, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, is_signed, A, B, cancel, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_iter_dp.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter_dp
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               op,
    input  logic [WIDTH-1:0]   load_lo,
    input  logic [WIDTH-1:0]   load_opnd,
    output logic               last,
    output logic [2*WIDTH-1:0] acc
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    // Upper half is the running sum (mult) or partial remainder (div);
    // lower half holds the multiplier or the dividend/quotient shift register.
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, load_lo};
            opnd_d = load_opnd;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op == OP_MUL) begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
    end

    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc  = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU over the iterative datapath and services MTHI/MTLO.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    hilo_muldiv_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               op_q, op_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;

    logic               a_neg, b_neg, dbz_start;
    logic [WIDTH-1:0]   a_mag, b_mag, dp_load_lo;
    logic               dp_load, dp_step, dp_last;
    logic [2*WIDTH-1:0] dp_acc;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign a_neg      = bus.is_signed & bus.A[WIDTH-1];
    assign b_neg      = bus.is_signed & bus.B[WIDTH-1];
    assign a_mag      = cond_neg(bus.A, a_neg);
    assign b_mag      = cond_neg(bus.B, b_neg);
    assign dbz_start  = (bus.op == OP_DIV) && (bus.B == '0);
    // A divide by zero skips iteration; the raw dividend rides in the lower half to FIX.
    assign dp_load_lo = dbz_start ? bus.A : a_mag;
    assign prod_fix   = cond_neg2(dp_acc, res_neg_q);

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (dp_load),
        .step      (dp_step),
        .op        (op_q),
        .load_lo   (dp_load_lo),
        .load_opnd (b_mag),
        .last      (dp_last),
        .acc       (dp_acc)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mthi) hi_d = bus.wdata;
                if (bus.mtlo) lo_d = bus.wdata;
                if (bus.start) begin
                    dp_load   = 1'b1;
                    op_d      = bus.op;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dbz_d     = dbz_start;
                    busy_d    = 1'b1;
                    state_d   = dbz_start ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    dbz_d   = 1'b0;
                end else begin
                    dp_step = 1'b1;
                    if (dp_last) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (bus.cancel) begin
                    dbz_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (dbz_q) begin
                        hi_d = dp_acc[WIDTH-1:0];
                        lo_d = {WIDTH{DIV0_LO_FILL}};
                    end else if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = prod_fix;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend.
                        lo_d = cond_neg(dp_acc[WIDTH-1:0], res_neg_q);
                        hi_d = cond_neg(dp_acc[2*WIDTH-1:WIDTH], rem_neg_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_q      <= OP_MUL;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_q      <= op_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed ops push expectations, a done-monitor pops and compares.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("op%0d_hi", e.id),      bus.hi,          e.hi);
                chk($sformatf("op%0d_lo", e.id),      bus.lo,          e.lo);
                chk($sformatf("op%0d_dbz", e.id),     bus.div_by_zero, e.dbz);
                chk($sformatf("op%0d_latency", e.id), cyc,             e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; optionally pushes the expected commit.
    task automatic issue(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edbz, input int id);
        exp_t e;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dbz = edbz;
            e.cyc = cyc + (edbz ? 2 : W + 2);
            e.id  = id;
            sb.push_back(e);
        end
        bus.start     = 1'b1;
        bus.op        = op;
        bus.is_signed = sgn;
        bus.A         = a;
        bus.B         = b;
        tick();
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("busy_timeout", bus.busy, 64'd0);
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.is_signed = 0; bus.A = '0; bus.B = '0;
        bus.cancel = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0;

        #12;
        chk("rst_hi",   bus.hi, 64'd0);
        chk("rst_lo",   bus.lo, 64'd0);
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_dbz",  bus.div_by_zero, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MT writes in IDLE
        bus.mthi = 1; bus.wdata = 32'h0000AAAA;
        tick();
        bus.mthi = 0;
        chk("mthi_hi", bus.hi, 64'h0000AAAA);
        chk("mthi_lo", bus.lo, 64'd0);
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h00001111;
        tick();
        bus.mthi = 0; bus.mtlo = 0;
        chk("mthilo_hi", bus.hi, 64'h00001111);
        chk("mthilo_lo", bus.lo, 64'h00001111);

        // Unsigned multiply with busy window
        issue(OP_MUL, 0, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 32'hFFFFFFFE, 0, 1);
        chk("mul_busy_t0", bus.busy, 64'd1);
        repeat (32) tick();
        chk("mul_busy_t32", bus.busy, 64'd1);
        chk("mul_done_t32", bus.done, 64'd0);
        tick();
        chk("mul_busy_t33", bus.busy, 64'd0);
        chk("mul_done_t33", bus.done, 64'd1);
        tick();

        issue(OP_MUL, 1, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 2);
        wait_idle();
        issue(OP_DIV, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 3);
        wait_idle();
        issue(OP_DIV, 1, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0, 4);
        wait_idle();
        issue(OP_DIV, 0, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 5);
        wait_idle();
        issue(OP_DIV, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 0, 6);
        wait_idle();

        // Divide by zero, then sticky flag
        issue(OP_DIV, 0, 32'h00001234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 1, 7);
        chk("dbz_busy_t0", bus.busy, 64'd1);
        wait_idle();
        repeat (3) tick();
        chk("dbz_sticky", bus.div_by_zero, 64'd1);

        // Cancel mid-RUN: no commit, no done
        issue(OP_MUL, 0, 32'd3, 32'd3, 0, '0, '0, 0, 0);
        chk("cancel_dbz_cleared_by_start", bus.div_by_zero, 64'd0);
        repeat (10) tick();
        bus.cancel = 1;
        tick();
        bus.cancel = 0;
        chk("cancel_busy", bus.busy, 64'd0);
        chk("cancel_hi", bus.hi, 64'h00001234);
        chk("cancel_lo", bus.lo, 64'hFFFFFFFF);
        repeat (40) tick();
        chk("cancel_hi_late", bus.hi, 64'h00001234);

        // Start and mtlo while busy are ignored
        issue(OP_DIV, 0, 32'd1000, 32'd10, 1, 32'd0, 32'd100, 0, 8);
        repeat (5) tick();
        bus.mtlo = 1; bus.wdata = 32'h0000DEAD;
        bus.start = 1; bus.op = OP_MUL; bus.A = 32'd5; bus.B = 32'd5;
        tick();
        bus.mtlo = 0; bus.start = 0; bus.A = '0; bus.B = '0;
        chk("busy_mtlo_ignored", bus.lo, 64'hFFFFFFFF);
        wait_idle();
        repeat (40) tick();

        // MTHI and start in the same IDLE cycle
        bus.mthi = 1; bus.wdata = 32'h00000077;
        issue(OP_MUL, 0, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 9);
        bus.mthi = 0;
        chk("mthi_with_start", bus.hi, 64'h00000077);
        wait_idle();
        tick();

        // Asynchronous reset mid-RUN
        bus.mthi = 1; bus.wdata = 32'h00005A5A;
        tick();
        bus.mthi = 0;
        issue(OP_MUL, 0, 32'h0000FFFF, 32'h0000FFFF, 0, '0, '0, 0, 0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstrun_hi",   bus.hi, 64'd0);
        chk("rstrun_lo",   bus.lo, 64'd0);
        chk("rstrun_busy", bus.busy, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) tick();
        chk("rstrun_idle", bus.busy, 64'd0);

        chk("sb_drained", sb.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
